// File: rtl/pic_ctl.sv
// pic_ctl: single-level interrupt controller with mask, toggle irq and EOI port
module pic_ctl #(
  parameter logic [7:0]  VBASE     = 8'd8,
  parameter logic [15:0] PORT_CMD  = 16'h0020,
  parameter logic [15:0] PORT_DATA = 16'h0021
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] port_a,
  input  logic        port_w,
  input  logic        port_r,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  output logic        irq,
  output logic [7:0]  irq_in,
  output logic [7:0]  isr
);
  logic [7:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d, vec_q, vec_d, pi_q, pi_d;
  logic       irq_q, irq_d;
  logic [7:0] pend, sel, grant;
  logic [2:0] n;
  logic       disp, wr_cmd, wr_dat, rd_cmd, rd_dat, eoi_all, eoi_one;
  // Pick the lowest unmasked pending line; set-beats-clear on irr, dispatch wins over EOI on isr.
  always_comb begin
    pend = irr_q & ~imr_q;
    disp = (isr_q == 8'h00) && (pend != 8'h00);
    sel = pend & (~pend + 8'd1);
    grant = disp ? sel : 8'h00;
    n = 3'd0;
    for (int i = 7; i >= 0; i--) n = pend[i] ? 3'(i) : n;
    wr_cmd = port_w && (port_a == PORT_CMD);
    wr_dat = port_w && (port_a == PORT_DATA);
    rd_cmd = port_r && (port_a == PORT_CMD);
    rd_dat = port_r && (port_a == PORT_DATA);
    eoi_all = wr_cmd && (port_o == 8'h20);
    eoi_one = wr_cmd && (port_o[7:3] == 5'b01100);
    irr_d = (irr_q & ~grant) | req;
    isr_d = (eoi_all ? 8'h00 : eoi_one ? isr_q & ~(8'h01 << port_o[2:0]) : isr_q) | grant;
    imr_d = wr_dat ? port_o : imr_q;
    irq_d = irq_q ^ disp;
    vec_d = disp ? VBASE + {5'd0, n} : vec_q;
    pi_d = rd_cmd ? irr_q : rd_dat ? imr_q : pi_q;
  end
  // Register all controller state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      irr_q <= 8'h00;
      imr_q <= 8'h00;
      isr_q <= 8'h00;
      vec_q <= 8'h00;
      pi_q  <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      irr_q <= irr_d;
      imr_q <= imr_d;
      isr_q <= isr_d;
      vec_q <= vec_d;
      pi_q  <= pi_d;
      irq_q <= irq_d;
    end
  end
  assign port_i = pi_q;
  assign irq    = irq_q;
  assign irq_in = vec_q;
  assign isr    = isr_q;
endmodule

// File: doc/pic_ctl.md
Name: pic_ctl

Overview:
- Single-level programmable interrupt controller between peripheral event strobes (timer, PS/2 keyboard, vretrace, spare) and the core's `irq`/`irq_in` inputs.
- Latches request pulses and applies a mask register.
- Dispatches the highest-priority unmasked request as a toggle on `irq` together with a vector number.
- Blocks further dispatch until the CPU issues EOI through the I/O port interface.

Parameters:
- VBASE, 8'd8: vector number for line 0; line n produces VBASE+n.
- PORT_CMD, 16'h0020: command port (EOI write, IRR read).
- PORT_DATA, 16'h0021: mask port (IMR write/read).

Ports:
- clock  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous reset, active high.
- req  in  8  request strobes, one-cycle pulses; bit 0 has highest priority.
- port_a  in  16  CPU I/O address.
- port_w  in  1  I/O write strobe, one cycle.
- port_r  in  1  I/O read strobe, one cycle.
- port_o  in  8  CPU write data.
- port_i  out  8  registered read data.
- irq  out  1  toggle line to the core; each edge is one interrupt.
- irq_in  out  8  vector number, valid from the cycle `irq` toggles.
- isr  out  8  in-service register (debug/LEDs).

Behaviour:
- Reset: irr=0, imr=0 (all lines enabled), isr=0, irq=0, irq_in=0, port_i=0. Reset asserted mid-service drops all pending and in-service state; `irq` returns to 0, which may itself be an edge. The core is reset in the same cycle.
- Registers: irr[7:0] (pending), imr[7:0] (mask), isr[7:0] (in service, at most one bit set).
- Request latch: a `req[n]` pulse sets irr[n] on the next edge. A request while irr[n] is already set is absorbed (no counting). Masked lines still latch into irr and stay pending.
- Dispatch condition, evaluated every cycle on registered state: isr==0 and (irr & ~imr)!=0.
- Dispatch action, next edge:
  - n = lowest set index of (irr & ~imr);
  - isr[n]<=1, irr[n]<=0, irq<=~irq, irq_in<=VBASE+n (8-bit, wraps modulo 256).
- Latency: `req` pulse at cycle t, controller idle → `irq` toggles at the edge ending cycle t+1 (visible in t+2).
- Set beats clear: if `req[n]` pulses in the same cycle irr[n] is dispatched, irr[n] stays 1 (new pending request).
- Single level: while any isr bit is set, no dispatch occurs, regardless of priority.
- Command port write (port_w, port_a==PORT_CMD):
  - port_o==8'h20: non-specific EOI, isr<=0.
  - port_o[7:3]==5'b01100 (60h+n): specific EOI, clears isr[n] only.
  - Any other value: ignored.
- Dispatch after EOI: EOI takes effect at the edge; dispatch can occur no earlier than the following edge (one idle cycle minimum between EOI and the next toggle).
- Data port write (port_w, port_a==PORT_DATA): imr<=port_o. A write in the same cycle as a dispatch: the dispatch uses the old imr.
- Reads (port_r): port_i is updated at the next edge and otherwise holds.
  - PORT_CMD returns irr.
  - PORT_DATA returns imr.
  - Other addresses: port_i unchanged.
- Port strobes at non-matching addresses are ignored entirely.
- Simultaneous port_w and port_r to matching addresses: both are performed. A read of irr returns the value before this edge's updates.

Test Plan:
1. After reset, pulse req[2] at cycle 5 → irq 0→1 visible at cycle 7, irq_in=8'd10, isr=8'h04, irr=0.
2. Pulse req[1] and req[4] in the same cycle → dispatch line 1 (irq_in=9). No second toggle until port_w PORT_CMD/8'h20. Then exactly one more toggle with irq_in=12, one cycle after isr clears.
3. Write imr=8'h01, pulse req[0] → no toggle, read PORT_CMD gives port_i=8'h01. Write imr=8'h00 → toggle with irq_in=8 on the next cycle.
4. While line 3 is in service, pulse req[3] twice → irr[3]=1 once. After EOI 8'h63 → one toggle, irq_in=11. A third req[3] in the dispatch cycle → irr[3] remains 1.
5. Write PORT_CMD 8'h55 while in service → isr unchanged. Write 8'h61 while isr=8'h04 → isr unchanged.
6. Assert reset while isr=8'h02 and irr=8'hF0 → all registers 0, irq=0. No dispatch for 2 cycles after release until a new req pulse.
